color_quan_pipe: RTL

- Pipelined, parametrised colour quantizer for the live style-transfer video path. Sits between pixel capture/format conversion and the style filters.
- Maps each channel of each pixel onto 2^L uniform levels.
- Adds runtime level count and reconstruction mode, both latched per frame. Uses a valid/ready stream with stall support and SOF/EOL sideband pass-through.

---
 rtl/color_quan_pkg.sv | 16 +
 rtl/color_quan_ch.sv | 60 ++++++
 rtl/color_quan_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/color_quan_pkg.sv
// color_quan_pkg: shared mode encoding, default mode and the 2x2 Bayer dither table
package color_quan_pkg;

    typedef enum logic [1:0] {
        MODE_CEIL   = 2'd0,
        MODE_FLOOR  = 2'd1,
        MODE_MID    = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

    localparam mode_e DEFAULT_MODE = MODE_CEIL;

    // Indexed by {py, px}: T = {{0,2},{3,1}}
    localparam logic [3:0][1:0] BAYER = {2'd1, 2'd3, 2'd2, 2'd0};

endpackage

// File: rtl/color_quan_ch.sv
// color_quan_ch: one channel of the quantizer; stage 1 dithers and bins, stage 2 reconstructs
module color_quan_ch
    import color_quan_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LEVEL_BITS = 3,
    localparam int LW        = $clog2(LEVEL_BITS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_x,
    input  logic [LW-1:0]     i_lvl1,
    input  mode_e             i_mode1,
    input  logic [1:0]        i_dith,
    input  logic [LW-1:0]     i_lvl2,
    input  mode_e             i_mode2,
    output logic [DATA_W-1:0] o_q
);

    localparam int SW = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MAXV = '1;

    logic [SW-1:0]     w_s1, w_s2;
    logic [DATA_W+1:0] w_off, w_sum;
    logic [DATA_W-1:0] w_xd, w_lo, w_mid;
    logic [DATA_W:0]   w_hi;
    logic [DATA_W-1:0] r_bin, r_q;

    assign w_s1  = SW'(DATA_W) - SW'(i_lvl1);
    assign w_off = ((DATA_W + 2)'(i_dith) << w_s1) >> 2;
    assign w_sum = (DATA_W + 2)'(i_x) + w_off;
    assign w_xd  = |w_sum[DATA_W+1:DATA_W] ? MAXV : w_sum[DATA_W-1:0];

    // Stage 1: bin index of the dithered sample; bypass carries the raw sample instead
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_bin <= '0;
        else if (i_en)
            r_bin <= (i_mode1 == MODE_BYPASS) ? i_x : w_xd >> w_s1;
    end

    assign w_s2  = SW'(DATA_W) - SW'(i_lvl2);
    assign w_lo  = r_bin << w_s2;
    assign w_hi  = ((DATA_W + 1)'(r_bin) + (DATA_W + 1)'(1)) << w_s2;
    assign w_mid = w_lo + ((DATA_W'(1) << w_s2) >> 1);

    // Stage 2: reconstruct the level; the top bin's ceiling saturates to full scale
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_q <= '0;
        else if (i_en)
            r_q <= (i_mode2 == MODE_CEIL)  ? (w_hi[DATA_W] ? MAXV : w_hi[DATA_W-1:0]) :
                   (i_mode2 == MODE_FLOOR) ? w_lo :
                   (i_mode2 == MODE_MID)   ? w_mid : r_bin;
    end

    assign o_q = r_q;

endmodule

// File: rtl/color_quan_pipe.sv
// color_quan_pipe: 2-stage stream colour quantizer with per-frame config; COLOR_QUAN_DITHER_EN adds 2x2 ordered dither
module color_quan_pipe
    import color_quan_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 3,
    parameter int LEVEL_BITS = 3,
    localparam int LW        = $clog2(LEVEL_BITS + 1)
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [NUM_CH*DATA_W-1:0] iData,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic                     iSOF,
    input  logic                     iEOL,
    input  logic [LW-1:0]            iLevels,
    input  logic [1:0]               iMode,
    output logic [NUM_CH*DATA_W-1:0] oData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic                     oSOF,
    output logic                     oEOL
);

    logic          w_en, w_acc, w_load;
    logic [LW-1:0] w_lvl, r_act_l, r_l1;
    mode_e         w_mode, r_act_mode, r_m1;
    logic [1:0]    w_dith;
    logic          r_v1, r_sof1, r_eol1, r_v2, r_sof2, r_eol2;

    assign w_en   = !r_v2 || iReady;
    assign oReady = w_en;
    assign w_acc  = iValid && w_en;
    assign w_load = w_acc && iSOF;
    assign w_lvl  = !w_load               ? r_act_l :
                    (iLevels == '0)       ? LW'(1) :
                    (iLevels > LW'(LEVEL_BITS)) ? LW'(LEVEL_BITS) : iLevels;
    assign w_mode = w_load ? mode_e'(iMode) : r_act_mode;

`ifdef COLOR_QUAN_DITHER_EN
    logic r_px, r_py, w_px, w_py;

    assign w_px   = iSOF ? 1'b0 : r_px;
    assign w_py   = iSOF ? 1'b0 : r_py;
    assign w_dith = BAYER[{w_py, w_px}];

    // Pixel/line parity for the dither pattern, restarted at each frame
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_px <= 1'b0;
            r_py <= 1'b0;
        end else if (w_acc) begin
            r_px <= iEOL ? 1'b0 : ~w_px;
            r_py <= iEOL ? ~w_py : w_py;
        end
    end
`else
    assign w_dith = 2'd0;
`endif

    // Active config, reloaded only by an accepted start-of-frame beat
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_act_l    <= LW'(LEVEL_BITS);
            r_act_mode <= DEFAULT_MODE;
        end else if (w_load) begin
            r_act_l    <= w_lvl;
            r_act_mode <= w_mode;
        end
    end

    // Valid/sideband shift plus the per-beat config that stage 2 needs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_v1   <= 1'b0;
            r_sof1 <= 1'b0;
            r_eol1 <= 1'b0;
            r_l1   <= LW'(LEVEL_BITS);
            r_m1   <= DEFAULT_MODE;
            r_v2   <= 1'b0;
            r_sof2 <= 1'b0;
            r_eol2 <= 1'b0;
        end else if (w_en) begin
            r_v1   <= w_acc;
            r_sof1 <= w_acc && iSOF;
            r_eol1 <= w_acc && iEOL;
            r_l1   <= w_lvl;
            r_m1   <= w_mode;
            r_v2   <= r_v1;
            r_sof2 <= r_sof1;
            r_eol2 <= r_eol1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        color_quan_ch #(
            .DATA_W     (DATA_W),
            .LEVEL_BITS (LEVEL_BITS)
        ) u_ch (
            .i_clk   (iCLK),
            .i_rst   (iRST),
            .i_en    (w_en),
            .i_x     (iData[i*DATA_W +: DATA_W]),
            .i_lvl1  (w_lvl),
            .i_mode1 (w_mode),
            .i_dith  (w_dith),
            .i_lvl2  (r_l1),
            .i_mode2 (r_m1),
            .o_q     (oData[i*DATA_W +: DATA_W])
        );
    end

    assign oValid = r_v2;
    assign oSOF   = r_sof2;
    assign oEOL   = r_eol2;

endmodule
